// File: rtl/cpu_jtag_ocimem_pkg.sv
// cpu_jtag_ocimem_pkg: shared state encoding and jdo field positions for the ocimem sequencer
package cpu_jtag_ocimem_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;
    localparam int JDO_CLR_ERR  = 36;
    localparam int JDO_RD_GO    = 35;
    localparam int JDO_WDATA_HI = 34;
    localparam int JDO_WDATA_LO = 3;
    localparam int JDO_ADDR_LO  = 17;
    localparam logic [31:0] MONDREG_RESET = 32'h0;
endpackage

// File: rtl/cpu_jtag_ocimem_watchdog.sv
// cpu_jtag_ocimem_watchdog: counts busy cycles, flags the TIMEOUT_CYCLES-th one
module cpu_jtag_ocimem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] count_q, count_d;
    always_comb count_d = clear ? '0 : enable ? count_q + CW'(1) : count_q;
    assign expired = enable && !clear && count_q == LAST;
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/cpu_jtag_ocimem_sequencer.sv
// cpu_jtag_ocimem_sequencer: turns ocimem debug pulses into single-word debug memory accesses
module cpu_jtag_ocimem_sequencer
    import cpu_jtag_ocimem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_q, mon_d, wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, err_q, err_d;
    logic              expired, any_pulse, multi_pulse, complete, unused_jdo;
    assign unused_jdo  = ^{jdo[37], jdo[2:0]};
    assign any_pulse   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_pulse = (take_action_ocimem_a & take_action_ocimem_b)
                       | (take_action_ocimem_a & take_no_action_ocimem_a)
                       | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign complete    = (state_q == RD_WAIT && mem_readdatavalid)
                       || (state_q == WR_REQ && !mem_waitrequest);
    cpu_jtag_ocimem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .enable (state_q != IDLE),
        .expired(expired)
    );
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[JDO_ADDR_LO +: ADDR_W];
                    if (jdo[JDO_CLR_ERR]) err_d = 1'b0;
                    if (jdo[JDO_RD_GO]) begin
                        state_d = RD_REQ;
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
                    state_d = WR_REQ;
                    wr_d    = 1'b1;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD_REQ;
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                end
                // a clearing address load beats the collision error it would otherwise raise
                if (multi_pulse && !(take_action_ocimem_a && jdo[JDO_CLR_ERR])) err_d = 1'b1;
            end
            RD_REQ: if (!mem_waitrequest) begin
                rd_d    = 1'b0;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (mem_readdatavalid) begin
                mon_d   = mem_readdata;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = IDLE;
                ready_d = 1'b1;
            end
            WR_REQ: if (!mem_waitrequest) begin
                wr_d    = 1'b0;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
        if (state_q != IDLE) begin
            if (expired && !complete) begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                err_d   = 1'b1;
                state_d = IDLE;
                ready_d = 1'b1;
            end
            if (any_pulse) err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mon_q   <= MONDREG_RESET;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end
    assign mem_address   = addr_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
endmodule

// File: tb/tb_cpu_jtag_ocimem_sequencer.sv
// tb_cpu_jtag_ocimem_sequencer: vector table driving ocimem commands against a small bus slave
module tb_cpu_jtag_ocimem_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata, mem_readdata, MonDReg;
    logic        mem_readdatavalid, mem_waitrequest, monitor_ready, monitor_error;

    always #5 clk = ~clk;

    cpu_jtag_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    typedef struct {
        logic [63:0] name;
        bit a, b, n, clr, rdgo;
        logic [7:0] ld;
        logic [31:0] wd;
        int waits, lat;
        logic [31:0] rdata;
        int stray;
        bit acc, acc_wr;
        logic [7:0] acc_addr;
        int exp_cyc, exp_req;
        logic [7:0] exp_addr;
        logic [31:0] exp_mon;
        bit exp_err;
    } vec_t;

    typedef struct {
        bit wr;
        logic [7:0] addr;
        logic [31:0] data;
    } acc_t;

    vec_t vecs[12];
    acc_t sb[$];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] mk(input vec_t v);
        logic [37:0] j;
        j = {1'b0, v.clr, v.rdgo, v.wd, 3'b000};
        if (v.a) j[17 +: 8] = v.ld;
        return j;
    endfunction

    task automatic run(input vec_t v);
        int cyc, req, waits, pend;
        acc_t e;
        @(negedge clk);
        jdo = mk(v);
        take_action_ocimem_a = v.a;
        take_action_ocimem_b = v.b;
        take_no_action_ocimem_a = v.n;
        if (v.acc) sb.push_back('{v.acc_wr, v.acc_addr, v.wd});
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cyc = 1; req = 0; waits = v.waits; pend = 0;
        while (!monitor_ready && cyc < 64) begin
            take_action_ocimem_b = (cyc == v.stray);
            mem_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = v.rdata;
                end
            end
            mem_waitrequest = 1'b1;
            if (mem_read || mem_write) begin
                req++;
                if (waits > 0) waits--;
                else begin
                    mem_waitrequest = 1'b0;
                    if (mem_read) pend = v.lat;
                    if (sb.size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL %s acc_unexpected: got access at %h, expected none", v.name, mem_address);
                    end else begin
                        e = sb.pop_front();
                        chk("acc_kind", {31'b0, mem_write}, {31'b0, e.wr});
                        chk("acc_addr", {24'b0, mem_address}, {24'b0, e.addr});
                        if (e.wr) chk("acc_data", mem_writedata, e.data);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        take_action_ocimem_b = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest = 1'b1;
        $display("vector %s: %0d cycles to ready", v.name, cyc);
        chk("cycles", cyc, v.exp_cyc);
        chk("req_cycles", req, v.exp_req);
        chk("addr", {24'b0, mem_address}, {24'b0, v.exp_addr});
        chk("mondreg", MonDReg, v.exp_mon);
        chk("error", {31'b0, monitor_error}, {31'b0, v.exp_err});
        chk("rdwr_idle", {30'b0, mem_read, mem_write}, 32'h0);
        chk("sb_left", sb.size(), 0);
    endtask

    initial begin
        //            name        a  b  n clr rd  ld     wd            w   l  rdata        st acc wr aa     cyc req addr   mon           err
        vecs[0]  = '{"ldaddr",   1, 0, 0, 0, 0, 8'h10, 32'h0,        0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'h10, 32'h0,        0};
        vecs[1]  = '{"wr_wait2", 0, 1, 0, 0, 0, 8'h00, 32'hCAFEF00D, 2,  0, 32'h0,        0, 1, 1, 8'h10, 4, 3, 8'h11, 32'h0,        0};
        vecs[2]  = '{"rd_lat3",  1, 0, 0, 0, 1, 8'h10, 32'h0,        0,  3, 32'h12345678, 0, 1, 0, 8'h10, 5, 1, 8'h11, 32'h12345678, 0};
        vecs[3]  = '{"ld_ff",    1, 0, 0, 0, 0, 8'hFF, 32'h0,        0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'hFF, 32'h12345678, 0};
        vecs[4]  = '{"rd_wrap",  0, 0, 1, 0, 0, 8'h00, 32'h0,        1,  1, 32'hA5A50001, 2, 1, 0, 8'hFF, 4, 2, 8'h00, 32'hA5A50001, 1};
        vecs[5]  = '{"clr_err",  1, 0, 0, 1, 0, 8'h20, 32'h0,        0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'h20, 32'hA5A50001, 0};
        vecs[6]  = '{"col_bn",   0, 1, 1, 0, 0, 8'h00, 32'hDEADBEEF, 0,  0, 32'h0,        0, 1, 1, 8'h20, 2, 1, 8'h21, 32'hA5A50001, 1};
        vecs[7]  = '{"col_ab",   1, 1, 0, 1, 0, 8'h30, 32'hDEADBEEF, 0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'h30, 32'hA5A50001, 0};
        vecs[8]  = '{"col_an",   1, 0, 1, 0, 0, 8'h40, 32'h0,        0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'h40, 32'hA5A50001, 1};
        vecs[9]  = '{"clr2",     1, 0, 0, 1, 0, 8'h40, 32'h0,        0,  0, 32'h0,        0, 0, 0, 8'h00, 1, 0, 8'h40, 32'hA5A50001, 0};
        vecs[10] = '{"timeout",  0, 0, 1, 0, 0, 8'h00, 32'h0,     1000,  0, 32'h0,        0, 0, 0, 8'h00, 9, 8, 8'h40, 32'hA5A50001, 1};
        vecs[11] = '{"rd_after", 1, 0, 0, 1, 1, 8'h7F, 32'h0,        0,  2, 32'h5A5A1234, 0, 1, 0, 8'h7F, 4, 1, 8'h80, 32'h5A5A1234, 0};

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        mem_readdata = '0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, monitor_ready}, 32'h1);
        chk("rst_error", {31'b0, monitor_error}, 32'h0);
        chk("rst_addr", {24'b0, mem_address}, 32'h0);
        chk("rst_mon", MonDReg, 32'h0);
        chk("rst_wdata", mem_writedata, 32'h0);
        chk("rst_rdwr", {30'b0, mem_read, mem_write}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run(vecs[i]);

        // readdatavalid while idle must not touch MonDReg or the address
        @(negedge clk);
        mem_readdata = 32'hBAD0BAD0;
        mem_readdatavalid = 1'b1;
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        @(negedge clk);
        chk("stray_mon", MonDReg, 32'h5A5A1234);
        chk("stray_addr", {24'b0, mem_address}, 32'h80);
        chk("stray_ready", {31'b0, monitor_ready}, 32'h1);

        // reset in the middle of a stalled write, with the error flag set
        jdo = {3'b000, 32'h11112222, 3'b000};
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        chk("mid_wr_write", {31'b0, mem_write}, 32'h1);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        chk("mid_wr_err", {31'b0, monitor_error}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_write", {31'b0, mem_write}, 32'h0);
        chk("rst2_read", {31'b0, mem_read}, 32'h0);
        chk("rst2_ready", {31'b0, monitor_ready}, 32'h1);
        chk("rst2_error", {31'b0, monitor_error}, 32'h0);
        chk("rst2_addr", {24'b0, mem_address}, 32'h0);
        chk("rst2_mon", MonDReg, 32'h0);
        chk("rst2_wdata", mem_writedata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, monitor_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
